// File: rtl/pll_loop_filter_if.sv
// Phase-detector decision inputs and NCO tuning outputs of the PLL loop filter.
// The master drives decisions; the slave (loop filter) drives the tuning word and status.
interface pll_loop_filter_if #(
   parameter int FTW_WIDTH = 32
);
   logic                 pd_valid;
   logic                 pd_early;
   logic                 pd_late;
   logic                 hold;
   logic [FTW_WIDTH-1:0] ftw;
   logic                 ftw_valid;
   logic                 locked;
   logic                 sat;

   modport master (output pd_valid, pd_early, pd_late, hold,
                   input  ftw, ftw_valid, locked, sat);
   modport slave  (input  pd_valid, pd_early, pd_late, hold,
                   output ftw, ftw_valid, locked, sat);
endinterface

// File: rtl/pll_loop_filter.sv
// Bang-bang PI loop filter: early/late decisions -> NCO tuning word.
// Includes a clamped integrator and a window-based lock detector.
module pll_loop_filter #(
   parameter int                 FTW_WIDTH   = 32,
   parameter logic [FTW_WIDTH-1:0] FTW_NOMINAL = 32'h2000_0000,
   parameter int                 KP          = 1024,
   parameter int                 KI          = 16,
   parameter int                 INT_LIMIT   = 1048576,
   parameter int                 LOCK_WINDOW = 256,
   parameter int                 LOCK_THRESH = 8,
   parameter int                 LOCK_COUNT  = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   pll_loop_filter_if.slave bus
);
   localparam int W  = FTW_WIDTH;
   localparam int DW = $clog2(LOCK_WINDOW + 1);
   localparam int BW = $clog2(LOCK_WINDOW) + 2;
   localparam int GW = $clog2(LOCK_COUNT + 1);

   localparam logic signed [W:0]    KI_S    = (W+1)'(KI);
   localparam logic signed [W:0]    LIM_P   = (W+1)'(INT_LIMIT);
   localparam logic signed [W:0]    LIM_N   = -LIM_P;
   localparam logic [W-1:0]         KP_U    = W'(KP);
   localparam logic [DW-1:0]        WIN_END = DW'(LOCK_WINDOW - 1);
   localparam logic signed [BW-1:0] BAL_ONE = BW'(1);
   localparam logic signed [BW-1:0] THR     = BW'(LOCK_THRESH);
   localparam logic [GW-1:0]        GC_END  = GW'(LOCK_COUNT - 1);
   localparam logic [GW-1:0]        GC_ONE  = GW'(1);

   typedef enum logic [1:0] {UNLOCKED, ACQUIRING, LOCKED} state_e;

   state_e                 state_q;
   logic signed [W-1:0]    integ_q, integ_d;
   logic [W-1:0]           ftw_q, ftw_d, prop;
   logic                   ftw_valid_q, locked_q, sat_q, sat_d;
   logic [DW-1:0]          dec_cnt_q;
   logic signed [BW-1:0]   bal_q, bal_inc, bal_abs;
   logic [GW-1:0]          good_cnt_q;
   logic signed [W:0]      integ_sum;
   logic                   up, dn, win_close, good;

   // both-set, neither-set and hold all collapse to a no-op here
   assign up = bus.pd_valid & bus.pd_late & ~bus.pd_early & ~bus.hold;
   assign dn = bus.pd_valid & bus.pd_early & ~bus.pd_late & ~bus.hold;

   always_comb begin
      integ_sum = {integ_q[W-1], integ_q};
      if (up)      integ_sum = integ_sum + KI_S;
      else if (dn) integ_sum = integ_sum - KI_S;

      // one extra bit so the clamp sees the true sum before truncation
      if (integ_sum > LIM_P)      integ_d = LIM_P[W-1:0];
      else if (integ_sum < LIM_N) integ_d = LIM_N[W-1:0];
      else                        integ_d = integ_sum[W-1:0];

      sat_d = (integ_d == LIM_P[W-1:0]) || (integ_d == LIM_N[W-1:0]);

      prop = '0;
      if (up)      prop = KP_U;
      else if (dn) prop = -KP_U;
      ftw_d = FTW_NOMINAL + W'(integ_d) + prop;
   end

   always_comb begin
      bal_inc   = up ? bal_q + BAL_ONE : bal_q - BAL_ONE;
      bal_abs   = bal_inc[BW-1] ? -bal_inc : bal_inc;
      good      = bal_abs <= THR;
      win_close = (up | dn) && (dec_cnt_q == WIN_END);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         integ_q     <= '0;
         ftw_q       <= FTW_NOMINAL;
         ftw_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         locked_q    <= 1'b0;
         dec_cnt_q   <= '0;
         bal_q       <= '0;
         good_cnt_q  <= '0;
         state_q     <= UNLOCKED;
      end else begin
         integ_q     <= integ_d;
         ftw_q       <= ftw_d;
         ftw_valid_q <= up | dn;
         sat_q       <= sat_d;
         if (up | dn) begin
            if (win_close) begin
               dec_cnt_q <= '0;
               bal_q     <= '0;
               case (state_q)
                  UNLOCKED: if (good) begin
                     good_cnt_q <= GC_ONE;
                     if (LOCK_COUNT == 1) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end else begin
                        state_q  <= ACQUIRING;
                     end
                  end
                  ACQUIRING: if (good) begin
                     good_cnt_q <= good_cnt_q + GC_ONE;
                     if (good_cnt_q == GC_END) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     state_q    <= UNLOCKED;
                     good_cnt_q <= '0;
                  end
                  LOCKED: if (!good) begin
                     state_q    <= UNLOCKED;
                     locked_q   <= 1'b0;
                     good_cnt_q <= '0;
                  end
                  default: begin
                     state_q    <= UNLOCKED;
                     locked_q   <= 1'b0;
                     good_cnt_q <= '0;
                  end
               endcase
            end else begin
               dec_cnt_q <= dec_cnt_q + DW'(1);
               bal_q     <= bal_inc;
            end
         end
      end
   end

   assign bus.ftw       = ftw_q;
   assign bus.ftw_valid = ftw_valid_q;
   assign bus.locked    = locked_q;
   assign bus.sat       = sat_q;
endmodule

// File: tb/tb_pll_loop_filter.sv
// Randomized and directed bench for pll_loop_filter against a behavioural model
// that tracks the integrator value, window tallies and run of consecutive good windows.
module tb_pll_loop_filter;
   localparam logic [31:0] NOM   = 32'h2000_0000;
   localparam longint      KP    = 1024;
   localparam longint      KI    = 16;
   localparam longint      LIM   = 1048576;
   localparam int          WIN   = 256;
   localparam int          THR   = 8;
   localparam int          LCNT  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pll_loop_filter_if #(.FTW_WIDTH(32)) bus ();
   pll_loop_filter dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   // model state
   longint      m_integ;
   int          m_dec, m_bal, m_run;
   logic [31:0] e_ftw;
   bit          e_valid, e_locked, e_sat;
   bit          chk_en;
   int          n_chk, n_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic model(input bit v, input bit e, input bit l, input bit h, input bit r);
      bit     up, dn, good;
      longint prop;
      if (r) begin
         m_integ = 0; m_dec = 0; m_bal = 0; m_run = 0;
         e_ftw = NOM; e_valid = 0; e_locked = 0; e_sat = 0;
         return;
      end
      up = v && l && !e && !h;
      dn = v && e && !l && !h;
      prop = 0;
      if (up) begin
         m_integ = (m_integ + KI > LIM) ? LIM : m_integ + KI;
         prop = KP;
      end else if (dn) begin
         m_integ = (m_integ - KI < -LIM) ? -LIM : m_integ - KI;
         prop = -KP;
      end
      if (up || dn) begin
         m_dec++;
         m_bal += up ? 1 : -1;
         if (m_dec == WIN) begin
            good  = (m_bal < 0 ? -m_bal : m_bal) <= THR;
            m_run = good ? m_run + 1 : 0;
            m_dec = 0; m_bal = 0;
         end
      end
      e_ftw    = NOM + 32'(m_integ) + 32'(prop);
      e_valid  = up || dn;
      e_sat    = (m_integ == LIM) || (m_integ == -LIM);
      e_locked = m_run >= LCNT;
   endtask

   task automatic step(input bit v, input bit e, input bit l, input bit h = 0, input bit r = 0);
      bus.pd_valid = v; bus.pd_early = e; bus.pd_late = l; bus.hold = h; rst = r;
      @(posedge clk);
      model(v, e, l, h, r);
      #1;
   endtask

   task automatic alt(input int n);
      for (int i = 0; i < n; i++) step(1, i[0], !i[0]);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ftw", bus.ftw, e_ftw);
         chk("ftw_valid", 32'(bus.ftw_valid), 32'(e_valid));
         chk("locked", 32'(bus.locked), 32'(e_locked));
         chk("sat", 32'(bus.sat), 32'(e_sat));
      end
   end

   initial begin
      chk_en = 0; n_chk = 0; n_pass = 0;
      bus.pd_valid = 0; bus.pd_early = 0; bus.pd_late = 0; bus.hold = 0; rst = 1;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk_en = 1;

      // idle after reset
      for (int i = 0; i < 10; i++) step(0, 0, 0);
      chk("rst_ftw", bus.ftw, 32'h2000_0000);
      chk("rst_locked", 32'(bus.locked), 32'd0);

      // single late pulse
      step(1, 0, 1);
      chk("late1_ftw", bus.ftw, 32'h2000_0410);
      chk("late1_vld", 32'(bus.ftw_valid), 32'd1);
      step(0, 0, 0);
      chk("late1_drop", bus.ftw, 32'h2000_0010);

      // no-ops: both set, hold
      step(1, 1, 1);
      step(1, 0, 1, 1);
      step(1, 1, 0, 1);
      chk("noop_ftw", bus.ftw, 32'h2000_0010);
      chk("noop_vld", 32'(bus.ftw_valid), 32'd0);

      // integrator saturation
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 65536; i++) step(1, 0, 1);
      chk("sat_ftw", bus.ftw, 32'h2010_0400);
      chk("sat_flag", 32'(bus.sat), 32'd1);
      step(1, 0, 1);
      chk("sat_hold", bus.ftw, 32'h2010_0400);
      step(1, 1, 0);
      chk("desat_ftw", bus.ftw, 32'h200F_FBF0);
      chk("desat_flag", 32'(bus.sat), 32'd0);
      step(0, 0, 0);
      chk("desat_drop", bus.ftw, 32'h200F_FFF0);

      // lock acquire, bal=+8 good, 256 late loses lock
      step(0, 0, 0, 0, 1);
      alt(1023);
      chk("pre_lock", 32'(bus.locked), 32'd0);
      alt(1);
      chk("lock", 32'(bus.locked), 32'd1);
      alt(248);
      for (int i = 0; i < 8; i++) step(1, 0, 1);
      chk("bal8_good", 32'(bus.locked), 32'd1);
      for (int i = 0; i < 255; i++) step(1, 0, 1);
      chk("pre_unlock", 32'(bus.locked), 32'd1);
      step(1, 0, 1);
      chk("unlock", 32'(bus.locked), 32'd0);
      alt(1024);
      chk("relock", 32'(bus.locked), 32'd1);
      alt(246);
      for (int i = 0; i < 10; i++) step(1, 0, 1);
      chk("bal10_bad", 32'(bus.locked), 32'd0);

      // reset mid-window after 3 good windows; decision alongside rst dropped
      step(0, 0, 0, 0, 1);
      alt(768 + 100);
      step(1, 0, 1, 0, 1);
      chk("mid_rst_ftw", bus.ftw, 32'h2000_0000);
      alt(768);
      chk("post_rst3", 32'(bus.locked), 32'd0);
      alt(256);
      chk("post_rst4", 32'(bus.locked), 32'd1);

      // randomized traffic
      begin
         int  mode;
         bit  tog;
         tog = 0;
         mode = 0;
         for (int i = 0; i < 6000; i++) begin
            bit v, e, l, h, r;
            int p;
            if (i % 256 == 0) mode = $urandom_range(0, 2);
            v = $urandom_range(0, 9) < 7;
            p = $urandom_range(0, 99);
            if (p < 4)       begin e = 1; l = 1; end
            else if (p < 7)  begin e = 0; l = 0; end
            else if (mode == 0) begin tog = !tog; e = tog; l = !tog; end
            else if (mode == 1) begin l = $urandom_range(0, 3) != 0; e = !l; end
            else begin l = $urandom_range(0, 1); e = !l; end
            h = $urandom_range(0, 49) == 0;
            r = $urandom_range(0, 2999) == 0;
            step(v, e, l, h, r);
         end
      end

      step(0, 0, 0);
      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
